detect_interval_fifo: RTL and testbench
=======================================

# detect_interval_fifo

- Sits directly downstream of the serial sequence detector and consumes its one-cycle `y` detection pulses.
- Measures the number of clock cycles between consecutive detections, saturating at the counter width, and buffers each interval in a small FIFO.
- A host drains the FIFO through a registered read handshake.
- Also keeps a running detection total and a sticky overflow flag for dropped intervals.

## Interface
Parameters:
- CNT_W, 8, width of the interval counter and of each FIFO entry
- DEPTH, 4, FIFO entries; must be a power of two, ≥2
- TOT_W, 16, width of the detection total counter

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
- y  input  1  detection pulse from the sequence detector; every cycle sampled high is one event
- rd_en  input  1  read request; pops the head entry when `empty`=0
- rd_data  output  CNT_W  popped interval; valid only while `rd_valid`=1
- rd_valid  output  1  one-cycle pulse, asserted the cycle after an accepted pop
- empty  output  1  FIFO holds no entries
- full  output  1  FIFO holds DEPTH entries
- count  output  $clog2(DEPTH)+1  current number of entries
- overflow  output  1  sticky; set when an interval is dropped because the FIFO is full
- total  output  TOT_W  detections seen since reset; wraps modulo 2^TOT_W

## Operation
- Interval counter `gap` (CNT_W bits):
  - Reset value 0.
  - Cycle with y=0: `gap` <= min(`gap`+1, 2^CNT_W−1).
  - Cycle with y=1: push value min(`gap`+1, 2^CNT_W−1), then `gap` <= 0.
- Resulting behaviour:
  - The interval is the edge-index difference between consecutive detections. Back-to-back y-high cycles give 1.
  - The first interval after reset is measured from reset release. Edge 1 is the first rising edge after release.
- FIFO storage:
  - DEPTH×CNT_W register array.
  - Write and read pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
  - An extra bit in `count` distinguishes full from empty.
- Push (y=1):
  - Accepted if `full`=0, or if a pop is accepted in the same cycle.
  - Otherwise the value is dropped and `overflow` <= 1.
- Pop (rd_en=1):
  - Accepted only if `empty`=0.
  - `rd_data` <= head entry and `rd_valid` <= 1 on that edge; read pointer advances.
  - rd_en while empty has no effect: `rd_valid`=0 next cycle, `rd_data` holds.
- Simultaneous push and pop:
  - Full: both accepted, `count` unchanged, no overflow.
  - Empty: pop ignored, push accepted, `count` becomes 1.
- `total` increments on every y=1 cycle, including dropped ones.
- `overflow` clears only on reset.
- No state machine beyond the pointers and counters. The FIFO state is fully encoded by `count`.

## Timing
- Reset (reset=0, asynchronous) forces:
  - `gap`=0, pointers=0, `count`=0
  - `empty`=1, `full`=0
  - `rd_valid`=0, `rd_data`=0
  - `overflow`=0, `total`=0
- Deassertion is sampled by the next rising edge.
- Reset asserted mid-operation discards all buffered intervals at once. No partial pop completes.
- Push-to-visibility:
  - An interval pushed at edge k updates `empty`/`count`/`full` after edge k.
  - It can be popped by rd_en sampled at edge k+1.
  - Its `rd_data`/`rd_valid` appear after edge k+1.
- `empty`, `full` and `count` are registered. `full` and `empty` are decoded from registered `count`.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- **Reset values:** hold reset=0 for 2 cycles, then release → `empty`=1, `full`=0, `count`=0, `rd_valid`=0, `overflow`=0, `total`=0.
- **Interval capture:** y=1 at edges 3, 5, 9 after release, no reads; then rd_en for 3 cycles.
  - `count` reaches 3 and `total`=3.
  - Reads return 3, 2, 4, each with a `rd_valid` pulse; `empty`=1 after the last pop.
- **Saturation:** with CNT_W=8, y=0 for 300 cycles, then one y pulse → popped interval = 255.
- **Overflow:** y=1 on 5 consecutive edges, no reads.
  - `full`=1 after the 4th push; 5th interval dropped; `overflow`=1; `total`=5.
  - Reads return 1, 1, 1, 1.
- **Full with simultaneous push and pop:** FIFO full, rd_en=1 and y=1 on the same edge.
  - `count` stays 4, `overflow` stays 0, `rd_valid`=1 with the oldest entry.
  - The new interval is the 4th entry read afterwards.
- **Mid-operation reset:** with `count`=2, pull reset low between edges.
  - Outputs immediately go to reset values: `empty`=1, `count`=0, `total`=0.
  - After release, y at edge 2 pushes interval 2.

Source files
------------

// File: rtl/detect_interval_fifo.sv
// rtl/detect_interval_fifo.sv - measures cycles between detection pulses and buffers them in a FIFO
module detect_interval_fifo #(
  parameter int CNT_W = 8,
  parameter int DEPTH = 4,
  parameter int TOT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     y,
  input  logic                     rd_en,
  output logic [CNT_W-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [TOT_W-1:0]         total
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] GAP_MAX  = '1;
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] gap_inc;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;
  logic [TOT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] mem_q [DEPTH];
  logic             fifo_empty, fifo_full;
  logic             pop_ok, push_ok;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);

  // A full FIFO still accepts a push when a pop frees the head slot on the same edge.
  assign pop_ok  = rd_en && !fifo_empty;
  assign push_ok = y && (!fifo_full || pop_ok);
  assign gap_inc = (gap_q == GAP_MAX) ? GAP_MAX : gap_q + 1'b1;

  always_comb begin
    gap_d      = y ? '0 : gap_inc;
    wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rd_data_d  = pop_ok ? mem_q[rd_ptr_q] : rd_data_q;
    rd_valid_d = pop_ok;
    overflow_d = overflow_q | (y & ~push_ok);
    total_d    = y ? total_q + 1'b1 : total_q;
    count_d    = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gap_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      total_q    <= '0;
    end else begin
      gap_q      <= gap_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
      total_q    <= total_d;
    end
  end

  // Entry storage needs no reset; occupancy is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= gap_inc;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign empty    = fifo_empty;
  assign full     = fifo_full;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign total    = total_q;

endmodule

// File: tb/tb_detect_interval_fifo.sv
// tb/tb_detect_interval_fifo.sv - scoreboard bench for detect_interval_fifo
module tb_detect_interval_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic        y;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        empty;
  logic        full;
  logic [2:0]  count;
  logic        overflow;
  logic [15:0] total;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_q [$];
  logic [7:0] exp_v;

  detect_interval_fifo #(.CNT_W(8), .DEPTH(4), .TOT_W(16)) dut (
    .clk(clk), .reset(reset), .y(y), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
    .count(count), .overflow(overflow), .total(total)
  );

  always #5 clk = ~clk;

  // Every rd_valid pulse must carry the oldest expected interval.
  always @(negedge clk) begin
    if (rd_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got rd_data=%0d, required no pop", rd_data);
      end else begin
        exp_v = exp_q.pop_front();
        if (rd_data !== exp_v) begin
          n_fail++;
          $display("FAIL pop_data: got %0d, required %0d", rd_data, exp_v);
        end
      end
    end
  end

  task automatic cyc(input logic yv, input logic rv);
    y = yv;
    rd_en = rv;
    @(posedge clk);
    #1;
    y = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    y = 1'b0;
    rd_en = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic check_drained(input string name);
    cyc(1'b0, 1'b0);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d pending, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({empty, full, count, rd_valid, overflow, total} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL reset_values: got e=%b f=%b c=%0d v=%b o=%b t=%0d, required 1 0 0 0 0 0",
               empty, full, count, rd_valid, overflow, total);
    end
    n_cmp++;
    if (rd_data !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_rd_data: got %0d, required 0", rd_data);
    end
  endtask

  task automatic test_capture();
    apply_reset();
    cyc(0, 0); cyc(0, 0); cyc(1, 0); exp_q.push_back(8'd3);
    cyc(0, 0); cyc(1, 0); exp_q.push_back(8'd2);
    cyc(0, 0); cyc(0, 0); cyc(0, 0); cyc(1, 0); exp_q.push_back(8'd4);
    n_cmp++;
    if (count !== 3'd3 || total !== 16'd3) begin
      n_fail++;
      $display("FAIL capture_count: got count=%0d total=%0d, required 3 3", count, total);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1);
      n_cmp++;
      if (rd_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL capture_valid%0d: got %b, required 1", i, rd_valid);
      end
    end
    n_cmp++;
    if (empty !== 1'b1) begin
      n_fail++;
      $display("FAIL capture_empty: got %b, required 1", empty);
    end
    check_drained("capture");
    cyc(0, 1);
    n_cmp++;
    if (rd_valid !== 1'b0 || rd_data !== 8'd4) begin
      n_fail++;
      $display("FAIL read_when_empty: got v=%b d=%0d, required 0 4", rd_valid, rd_data);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    repeat (300) cyc(0, 0);
    cyc(1, 0); exp_q.push_back(8'd255);
    cyc(0, 1);
    check_drained("saturation");
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0); exp_q.push_back(8'd1);
    end
    n_cmp++;
    if (full !== 1'b1 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_full: got full=%b ovf=%b, required 1 0", full, overflow);
    end
    cyc(1, 0);
    n_cmp++;
    if (overflow !== 1'b1 || total !== 16'd5 || count !== 3'd4) begin
      n_fail++;
      $display("FAIL overflow_drop: got ovf=%b total=%0d count=%0d, required 1 5 4", overflow, total, count);
    end
    repeat (4) cyc(0, 1);
    check_drained("overflow");
    n_cmp++;
    if (empty !== 1'b1 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_sticky: got empty=%b ovf=%b, required 1 1", empty, overflow);
    end
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    cyc(1, 0); exp_q.push_back(8'd1);
    cyc(0, 0); cyc(1, 0); exp_q.push_back(8'd2);
    cyc(0, 0); cyc(0, 0); cyc(1, 0); exp_q.push_back(8'd3);
    cyc(0, 0); cyc(0, 0); cyc(0, 0); cyc(1, 0); exp_q.push_back(8'd4);
    repeat (4) cyc(0, 0);
    cyc(1, 1); exp_q.push_back(8'd5);
    n_cmp++;
    if (count !== 3'd4 || overflow !== 1'b0 || rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL full_push_pop: got count=%0d ovf=%b v=%b, required 4 0 1", count, overflow, rd_valid);
    end
    repeat (4) cyc(0, 1);
    check_drained("full_push_pop");
  endtask

  task automatic test_empty_push_pop();
    apply_reset();
    cyc(1, 1); exp_q.push_back(8'd1);
    n_cmp++;
    if (count !== 3'd1 || rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_push_pop: got count=%0d v=%b, required 1 0", count, rd_valid);
    end
    cyc(0, 1);
    check_drained("empty_push_pop");
  endtask

  task automatic test_mid_reset();
    apply_reset();
    cyc(1, 0); cyc(1, 0);
    n_cmp++;
    if (count !== 3'd2) begin
      n_fail++;
      $display("FAIL mid_reset_pre: got count=%0d, required 2", count);
    end
    #2 reset = 1'b0;
    exp_q.delete();
    #1;
    n_cmp++;
    if (empty !== 1'b1 || count !== 3'd0 || total !== 16'd0 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got e=%b c=%0d t=%0d f=%b, required 1 0 0 0", empty, count, total, full);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    cyc(0, 0); cyc(1, 0); exp_q.push_back(8'd2);
    cyc(0, 1);
    check_drained("mid_reset");
  endtask

  initial begin
    reset = 1'b0;
    y = 1'b0;
    rd_en = 1'b0;
    test_reset();
    test_capture();
    test_saturation();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
